// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: parametrised pipeline control.
// Merges per-stage stall requests into a freeze vector and turns MEM-stage
// exception codes into a flush window plus a one-cycle PC redirect.
// Optional feature macro: STALL_WDOG_EN (stall watchdog that forces an
// exception to EXC_VECTOR after WDOG_LIMIT consecutive stall cycles).
// Without the macro wdog_o is tied low and WDOG_LIMIT has no effect.

module pipe_ctrl_unit #(
    parameter int             NUM_STAGES = 6,
    parameter int             DW         = 32,
    parameter logic [DW-1:0]  INT_VECTOR = 'h20,
    parameter logic [DW-1:0]  EXC_VECTOR = 'h40,
    parameter int             FLUSH_LEN  = 1,
    parameter int             CNT_W      = 16,
    parameter int             WDOG_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic [31:0]           excepttype_i,
    input  logic [DW-1:0]         cp0_epc_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic                  flush_o,
    output logic [DW-1:0]         new_pc_o,
    output logic                  redirect_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      exc_count_o,
    output logic                  wdog_o
);

    // Exception codes with a dedicated redirect target; every other non-zero
    // code goes to EXC_VECTOR.
    localparam logic [31:0] CODE_INT  = 32'h01;
    localparam logic [31:0] CODE_ERET = 32'h0e;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    // The flush counter only has to hold FLUSH_LEN-1.
    localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    // A pipeline needs at least PC plus one stage, a flush must last at least
    // one cycle, and a zero watchdog limit would fire on every idle cycle.
    generate
        if (NUM_STAGES < 2 || FLUSH_LEN < 1 || WDOG_LIMIT < 1) begin : gIllegalParams
            $error("pipe_ctrl_unit: illegal parameters (NUM_STAGES>=2, FLUSH_LEN>=1, WDOG_LIMIT>=1)");
        end
    endgenerate

    logic [0:0]            state_q,    state_d;
    logic [FCW-1:0]        flushCnt_q, flushCnt_d;
    logic [DW-1:0]         pc_q,       pc_d;
    logic [CNT_W-1:0]      excCount_q, excCount_d;

    logic [NUM_STAGES-1:0] stallVec;
    logic                  excPending;
    logic                  wdogFire;
    logic                  accept;
    logic [DW-1:0]         target;

    // Stall merge: the highest requesting stage freezes itself and everything
    // upstream of it; the PC (bit 0) never raises a request of its own.
    always_comb begin : stallMerge
        logic acc;
        acc      = 1'b0;
        stallVec = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            acc         = acc | (stallreq_i[k] & (k != 0));
            stallVec[k] = acc;
        end
    end

    assign excPending = (excepttype_i != 32'h0);

`ifdef STALL_WDOG_EN
    localparam int WDW = $clog2(WDOG_LIMIT + 1);

    logic [WDW-1:0] wdogCnt_q, wdogCnt_d;

    // The watchdog fires one cycle after the stall run reaches the limit; a
    // real exception in that cycle takes priority and suppresses it.
    assign wdogFire = (state_q == IDLE) && !excPending
                      && (wdogCnt_q == WDW'(WDOG_LIMIT));

    // Count consecutive idle cycles in which the pipeline is actually frozen.
    always_comb begin
        wdogCnt_d = '0;
        if (state_q == IDLE && !accept && stallVec != '0) begin
            wdogCnt_d = wdogCnt_q + 1'b1;
        end
    end

    // Watchdog run-length register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdogCnt_q <= '0;
        end else begin
            wdogCnt_q <= wdogCnt_d;
        end
    end
`else
    assign wdogFire = 1'b0;
`endif

    assign accept = (state_q == IDLE) && (excPending || wdogFire);

    // Redirect target decode; a watchdog event carries code 0 and therefore
    // lands on EXC_VECTOR along with the other synchronous exceptions.
    always_comb begin
        case (excepttype_i)
            CODE_INT:  target = INT_VECTOR;
            CODE_ERET: target = cp0_epc_i;
            default:   target = EXC_VECTOR;
        endcase
    end

    // Next-state logic: accept in IDLE, then count down the flush window while
    // ignoring codes raised by the instructions being squashed.
    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        pc_d       = pc_q;
        excCount_d = excCount_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pc_d = target;
                    if (excCount_q != '1) begin
                        excCount_d = excCount_q + 1'b1;
                    end
                    if (FLUSH_LEN > 1) begin
                        state_d    = FLUSH;
                        flushCnt_d = FCW'(FLUSH_LEN - 1);
                    end
                end
            end
            FLUSH: begin
                flushCnt_d = flushCnt_q - 1'b1;
                if (flushCnt_q == FCW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset also aborts any flush window in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            flushCnt_q <= '0;
            pc_q       <= '0;
            excCount_q <= '0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
            pc_q       <= pc_d;
            excCount_q <= excCount_d;
        end
    end

    // Output decode; everything is held low while reset is asserted so the
    // pipeline sees no spurious stall, flush or redirect during reset.
    always_comb begin
        stall_o     = '0;
        flush_o     = 1'b0;
        new_pc_o    = '0;
        redirect_o  = 1'b0;
        busy_o      = 1'b0;
        exc_count_o = '0;
        wdog_o      = 1'b0;
        if (!rst) begin
            exc_count_o = excCount_q;
            if (state_q == FLUSH) begin
                flush_o  = 1'b1;
                busy_o   = 1'b1;
                new_pc_o = pc_q;
            end else if (accept) begin
                flush_o    = 1'b1;
                redirect_o = 1'b1;
                new_pc_o   = target;
                wdog_o     = wdogFire;
            end else begin
                stall_o = stallVec;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit.
// dut1 uses FLUSH_LEN=1 and is driven from a vector table; dut3 uses
// FLUSH_LEN=3 and WDOG_LIMIT=4 for the multi-cycle sequences. Both share the
// same stimulus. Watchdog expectations follow STALL_WDOG_EN.

module tb_pipe_ctrl_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  stallReq;
    logic [31:0] excType;
    logic [31:0] epc;

    logic [5:0]  d1Stall, d3Stall;
    logic        d1Flush, d3Flush;
    logic [31:0] d1NewPc, d3NewPc;
    logic        d1Redir, d3Redir;
    logic        d1Busy,  d3Busy;
    logic [15:0] d1Count, d3Count;
    logic        d1Wdog,  d3Wdog;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [5:0]  req;
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  stall;
        logic        flush;
        logic        redir;
        logic        busy;
        logic [31:0] pc;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[13];

    pipe_ctrl_unit #(.NUM_STAGES(6), .DW(32), .FLUSH_LEN(1), .CNT_W(16), .WDOG_LIMIT(255)) dut1 (
        .clk(clk), .rst(rst), .stallreq_i(stallReq), .excepttype_i(excType), .cp0_epc_i(epc),
        .stall_o(d1Stall), .flush_o(d1Flush), .new_pc_o(d1NewPc), .redirect_o(d1Redir),
        .busy_o(d1Busy), .exc_count_o(d1Count), .wdog_o(d1Wdog)
    );

    pipe_ctrl_unit #(.NUM_STAGES(6), .DW(32), .FLUSH_LEN(3), .CNT_W(16), .WDOG_LIMIT(4)) dut3 (
        .clk(clk), .rst(rst), .stallreq_i(stallReq), .excepttype_i(excType), .cp0_epc_i(epc),
        .stall_o(d3Stall), .flush_o(d3Flush), .new_pc_o(d3NewPc), .redirect_o(d3Redir),
        .busy_o(d3Busy), .exc_count_o(d3Count), .wdog_o(d3Wdog)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs just after the rising edge, then wait to the
    // falling edge where outputs are sampled.
    task automatic applyStimulus(input logic [5:0] req, input logic [31:0] exc,
                                 input logic [31:0] epcV, input logic rstV);
        @(posedge clk);
        #1;
        stallReq = req;
        excType  = exc;
        epc      = epcV;
        rst      = rstV;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkDut3(input string tag, input logic [5:0] stall, input logic flush,
                             input logic redir, input logic busy, input logic [31:0] pc,
                             input logic [15:0] cnt, input logic wdog);
        checkOutput({tag, ".stall"}, 32'(d3Stall), 32'(stall));
        checkOutput({tag, ".flush"}, 32'(d3Flush), 32'(flush));
        checkOutput({tag, ".redirect"}, 32'(d3Redir), 32'(redir));
        checkOutput({tag, ".busy"}, 32'(d3Busy), 32'(busy));
        checkOutput({tag, ".new_pc"}, d3NewPc, pc);
        checkOutput({tag, ".count"}, 32'(d3Count), 32'(cnt));
        checkOutput({tag, ".wdog"}, 32'(d3Wdog), 32'(wdog));
    endtask

    initial begin
        logic       fires;
        logic       inFlush;
        logic [15:0] wdCount;

        rst      = 1'b1;
        stallReq = '0;
        excType  = '0;
        epc      = '0;

        // req, exc, epc, stall, flush, redir, busy, new_pc, count-before-edge
        vecs[0]  = '{6'b001000, 32'h00, 32'h0,    6'b001111, 1'b0, 1'b0, 1'b0, 32'h0,    16'd0};
        vecs[1]  = '{6'b000100, 32'h00, 32'h0,    6'b000111, 1'b0, 1'b0, 1'b0, 32'h0,    16'd0};
        vecs[2]  = '{6'b001100, 32'h00, 32'h0,    6'b001111, 1'b0, 1'b0, 1'b0, 32'h0,    16'd0};
        vecs[3]  = '{6'b000001, 32'h00, 32'h0,    6'b000000, 1'b0, 1'b0, 1'b0, 32'h0,    16'd0};
        vecs[4]  = '{6'b100000, 32'h00, 32'h0,    6'b111111, 1'b0, 1'b0, 1'b0, 32'h0,    16'd0};
        vecs[5]  = '{6'b001000, 32'h01, 32'h0,    6'b000000, 1'b1, 1'b1, 1'b0, 32'h20,   16'd0};
        vecs[6]  = '{6'b000000, 32'h00, 32'h0,    6'b000000, 1'b0, 1'b0, 1'b0, 32'h0,    16'd1};
        vecs[7]  = '{6'b000000, 32'h0e, 32'h1234, 6'b000000, 1'b1, 1'b1, 1'b0, 32'h1234, 16'd1};
        vecs[8]  = '{6'b000000, 32'h77, 32'h1234, 6'b000000, 1'b1, 1'b1, 1'b0, 32'h40,   16'd2};
        vecs[9]  = '{6'b000000, 32'h08, 32'h0,    6'b000000, 1'b1, 1'b1, 1'b0, 32'h40,   16'd3};
        vecs[10] = '{6'b010000, 32'h00, 32'h0,    6'b011111, 1'b0, 1'b0, 1'b0, 32'h0,    16'd4};
        vecs[11] = '{6'b000000, 32'h0c, 32'h0,    6'b000000, 1'b1, 1'b1, 1'b0, 32'h40,   16'd4};
        vecs[12] = '{6'b000000, 32'h00, 32'h0,    6'b000000, 1'b0, 1'b0, 1'b0, 32'h0,    16'd5};

        // Reset with active inputs: every output must be held low.
        applyStimulus(6'b001000, 32'h01, 32'h0, 1'b1);
        checkDut3("rst", 6'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'd0, 1'b0);
        checkOutput("rst.d1stall", 32'(d1Stall), 32'h0);
        checkOutput("rst.d1flush", 32'(d1Flush), 32'h0);

        // Table-driven vectors on the single-cycle-flush instance.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].req, vecs[i].exc, vecs[i].epc, 1'b0);
            checkOutput($sformatf("vec%0d.stall", i), 32'(d1Stall), 32'(vecs[i].stall));
            checkOutput($sformatf("vec%0d.flush", i), 32'(d1Flush), 32'(vecs[i].flush));
            checkOutput($sformatf("vec%0d.redirect", i), 32'(d1Redir), 32'(vecs[i].redir));
            checkOutput($sformatf("vec%0d.busy", i), 32'(d1Busy), 32'(vecs[i].busy));
            checkOutput($sformatf("vec%0d.new_pc", i), d1NewPc, vecs[i].pc);
            checkOutput($sformatf("vec%0d.count", i), 32'(d1Count), 32'(vecs[i].cnt));
            checkOutput($sformatf("vec%0d.wdog", i), 32'(d1Wdog), 32'h0);
        end

        // Three-cycle flush window, squashed codes ignored, next code accepted.
        applyStimulus(6'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(6'b001000, 32'h08, 32'h0, 1'b0);
        checkDut3("flA.c1", 6'b0, 1'b1, 1'b1, 1'b0, 32'h40, 16'd0, 1'b0);
        applyStimulus(6'b001000, 32'h08, 32'h0, 1'b0);
        checkDut3("flA.c2", 6'b0, 1'b1, 1'b0, 1'b1, 32'h40, 16'd1, 1'b0);
        applyStimulus(6'b001000, 32'h08, 32'h0, 1'b0);
        checkDut3("flA.c3", 6'b0, 1'b1, 1'b0, 1'b1, 32'h40, 16'd1, 1'b0);
        applyStimulus(6'b000000, 32'h0c, 32'h0, 1'b0);
        checkDut3("flA.c4", 6'b0, 1'b1, 1'b1, 1'b0, 32'h40, 16'd1, 1'b0);
        applyStimulus(6'b000000, 32'h00, 32'h0, 1'b0);
        checkDut3("flA.c5", 6'b0, 1'b1, 1'b0, 1'b1, 32'h40, 16'd2, 1'b0);

        // Latched target held through the window while an eret is squashed.
        applyStimulus(6'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(6'b0, 32'h01, 32'h0, 1'b0);
        checkDut3("flB.c1", 6'b0, 1'b1, 1'b1, 1'b0, 32'h20, 16'd0, 1'b0);
        applyStimulus(6'b0, 32'h0e, 32'h1234, 1'b0);
        checkDut3("flB.c2", 6'b0, 1'b1, 1'b0, 1'b1, 32'h20, 16'd1, 1'b0);
        applyStimulus(6'b0, 32'h00, 32'h0, 1'b0);
        checkDut3("flB.c3", 6'b0, 1'b1, 1'b0, 1'b1, 32'h20, 16'd1, 1'b0);
        applyStimulus(6'b0, 32'h00, 32'h0, 1'b0);
        checkDut3("flB.c4", 6'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'd1, 1'b0);

        // Reset in the middle of the flush window.
        applyStimulus(6'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(6'b0, 32'h01, 32'h0, 1'b0);
        checkDut3("rstF.c1", 6'b0, 1'b1, 1'b1, 1'b0, 32'h20, 16'd0, 1'b0);
        applyStimulus(6'b001000, 32'h01, 32'h0, 1'b1);
        checkDut3("rstF.c2", 6'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'd0, 1'b0);
        applyStimulus(6'b001000, 32'h00, 32'h0, 1'b0);
        checkDut3("rstF.c3", 6'b001111, 1'b0, 1'b0, 1'b0, 32'h0, 16'd0, 1'b0);

        // Held EX stall: watchdog (limit 4) fires on cycle 5 only if enabled.
        applyStimulus(6'b0, 32'h0, 32'h0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(6'b001000, 32'h0, 32'h0, 1'b0);
`ifdef STALL_WDOG_EN
            fires   = (c == 5);
            inFlush = (c >= 5);
            wdCount = (c == 6) ? 16'd1 : 16'd0;
`else
            fires   = 1'b0;
            inFlush = 1'b0;
            wdCount = 16'd0;
`endif
            checkDut3($sformatf("wdog.c%0d", c), inFlush ? 6'b0 : 6'b001111, inFlush, fires,
                      inFlush && !fires, inFlush ? 32'h40 : 32'h0, wdCount, fires);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
